// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StData  = 2'd2
  } arb_state_e;

  localparam logic [1:0] SizeWord = 2'b10;
  localparam int unsigned DefaultWaitMax = 15;

endpackage

// File: rtl/mem_port_arbiter_wait_watchdog.sv
// Wait-cycle watchdog: counts stalled bus cycles and flags the cycle that would reach the limit.
module mem_port_arbiter_wait_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WaitMax = DefaultWaitMax
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [7:0] Limit = 8'(WaitMax - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires in the wait cycle whose increment would make the count reach WaitMax.
  assign timeout_o = en_i & (count_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and data access requesters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_MAX = DefaultWaitMax
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              o_ifStall,
  output logic              o_memStall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              o_busErr
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              bus_err_q, bus_err_d;
  logic              last_data_q, last_data_d;
  logic              drop_q, drop_d;
  logic              wd_clr, wd_timeout;
  logic              ret_cycle, fetch_ok;

  assign ret_cycle = if_valid_q | d_valid_q;
  assign fetch_ok  = if_req & ~if_cancel;

  mem_port_arbiter_wait_watchdog #(
    .WaitMax (WAIT_MAX)
  ) u_wait_watchdog (
    .clk_i     (clk),
    .rst_ni    (reset_x),
    .clr_i     (wd_clr),
    .en_i      (mem_req_q & ~mem_ready),
    .timeout_o (wd_timeout)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    bus_err_d   = 1'b0;
    last_data_d = last_data_q;
    drop_d      = drop_q;
    wd_clr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A return cycle still sees the completed requester's held req; skip it.
        if (!ret_cycle) begin
          if (d_req && (!fetch_ok || !last_data_q)) begin
            state_d     = StData;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_size_d  = d_size;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            wd_clr      = 1'b1;
          end else if (fetch_ok) begin
            state_d     = StFetch;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_size_d  = SizeWord;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            drop_d      = 1'b0;
            wd_clr      = 1'b1;
          end
        end
      end
      StFetch: begin
        if (if_cancel) begin
          drop_d = 1'b1;
        end
        if (mem_ready) begin
          state_d     = StIdle;
          mem_req_d   = 1'b0;
          last_data_d = 1'b0;
          if (!drop_q && !if_cancel) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (wd_timeout) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      StData: begin
        if (mem_ready) begin
          state_d     = StIdle;
          mem_req_d   = 1'b0;
          last_data_d = 1'b1;
          d_valid_d   = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else if (wd_timeout) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      last_data_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      bus_err_q   <= bus_err_d;
      last_data_q <= last_data_d;
      drop_q      <= drop_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_size   = mem_size_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign if_valid   = if_valid_q;
  assign d_valid    = d_valid_q;
  assign o_busErr   = bus_err_q;
  assign o_ifStall  = if_req & ~if_valid_q;
  assign o_memStall = d_req & ~d_valid_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified single-port memory bus between the pipeline's instruction fetch (IF) and data access (MEM) requesters. Each request becomes a registered bus transaction with a req/ready handshake. The block returns read data to the requester and drives per-stage stall signals into the hazard logic, which turns them into the datapath's fetch, decode and flush controls. A wait-cycle watchdog flags a bus error if memory never answers.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
WAIT_MAX, 15, maximum cycles with mem_req high and no mem_ready before a bus error (1..255)

Ports:
clk  in  1  clock, rising edge
reset_x  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  ADDR_W  fetch address (PC)
if_cancel  in  1  redirect/flush; drop the outstanding or pending fetch
if_rdata  out  DATA_W  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_valid
d_we  in  1  1 = store, 0 = load
d_size  in  2  access size, forwarded to the bus
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid with d_valid
d_valid  out  1  one-cycle data completion pulse
o_ifStall  out  1  if_req & ~if_valid
o_memStall  out  1  d_req & ~d_valid
mem_req  out  1  bus request, held until mem_ready
mem_we  out  1  bus write enable
mem_size  out  2  bus access size; fetch uses 2'b10 (word)
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_rdata  in  DATA_W  bus read data, valid when mem_ready
mem_ready  in  1  bus completion, single-cycle pulse
o_busErr  out  1  one-cycle watchdog timeout pulse

Behaviour:
- Reset (asynchronous, immediate): state IDLE. All registered outputs go to 0: mem_*, if_rdata, d_rdata, if_valid, d_valid, o_busErr. lastData = 0, wait counter = 0. A transaction in progress is abandoned and mem_req drops immediately.
- States:
  - IDLE: no bus activity.
  - FETCH: fetch transaction in progress.
  - DATA: data transaction in progress.
- Grant rule, evaluated in IDLE only:
  - No grant in a cycle where if_valid or d_valid is high (return cycle), so a stale held request is not re-issued.
  - d_req only, or both requests with lastData = 0: grant data and go to DATA.
  - if_req & ~if_cancel only, or both with lastData = 1: grant fetch and go to FETCH.
  - Otherwise stay in IDLE.
- Grant cycle N: mem_addr, mem_we, mem_size and mem_wdata are registered from the winner. mem_req = 1 from N+1 and stays stable until completion.
- FETCH or DATA, on mem_ready in cycle M:
  - mem_req = 0 and state = IDLE at M+1.
  - The matching *_valid is 1 for exactly cycle M+1, and *_rdata holds mem_rdata captured at M until the next completion.
  - lastData = 1 after a data completion, 0 after a fetch completion.
  - Stores return d_valid with d_rdata unchanged.
- Minimum latency: request seen in IDLE at N, mem_ready at N+1, valid at N+2. Back-to-back transactions are separated by one return cycle.
- Cancel:
  - if_cancel in FETCH sets a drop flag. The bus transaction still completes (no bus abort), but if_valid stays 0 and if_rdata is not updated.
  - if_cancel in IDLE suppresses a fetch grant that cycle.
  - if_cancel has no effect on DATA.
- Watchdog:
  - An 8-bit counter clears at grant and increments each cycle that mem_req = 1 and mem_ready = 0.
  - When it reaches WAIT_MAX: o_busErr = 1 for one cycle, mem_req = 0, state = IDLE, no *_valid.
  - A mem_ready arriving in the same cycle as the timeout wins; the transaction completes normally.
- mem_ready while in IDLE is ignored.
- The stall outputs are combinational from the inputs and the registered valids. o_memStall takes precedence in the hazard logic; the block does not combine the two.
- Request inputs need only be stable while *_req is high. They are sampled once, at grant.

Decomposition:
- Shared package/header: state encoding (IDLE=2'd0, FETCH=2'd1, DATA=2'd2), fetch size constant SIZE_WORD=2'b10, and the default WAIT_MAX.
- One natural sub-module, wait_watchdog: counter, clear, enable, timeout compare. It is reusable by later bus blocks. The rest is a single FSM.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x10000, mem_ready 2 cycles after mem_req, mem_rdata=0x00000013 -> mem_addr=0x10000, mem_size=2'b10, if_valid pulse, if_rdata=0x00000013, o_ifStall=1 until the pulse cycle.
- Simultaneous requests after reset: if_req and d_req (load at 0x2000) asserted together -> data granted first, d_valid, then fetch granted after one return cycle. With both held continuously, grants alternate D,F,D,F.
- Store: d_we=1, d_size=2'b00, d_addr=0x2003, d_wdata=0xA5 -> mem_we=1, mem_size=2'b00, mem_addr=0x2003, mem_wdata=0xA5, d_valid pulse, d_rdata unchanged.
- Cancel: if_cancel pulsed during FETCH -> bus completes, no if_valid, if_rdata keeps its old value. The next fetch to 0x10040 returns normally.
- Timeout: WAIT_MAX=15, mem_ready never asserted -> o_busErr pulses on the 15th wait cycle, mem_req=0, state IDLE. Repeat with mem_ready in that same cycle -> normal completion, no error.
- Reset mid-transaction: reset_x low while mem_req=1 -> mem_req, valids and rdata are 0 immediately. After release with if_req=1, a fresh fetch grant occurs.
